// File: rtl/axis_width_conv.sv
// axis_width_conv
//   AXI-Stream data-width converter for the 40G MAC path. A single parametrised
//   core covers three cases, selected at elaboration:
//     IN_WIDTH > OUT_WIDTH : down-size. Each input beat is split into sub-beats.
//                            On a last beat, trailing all-empty sub-beats are dropped.
//     IN_WIDTH < OUT_WIDTH : up-size. Input beats are packed into output words.
//                            A word is flushed early at end of packet, and its
//                            unfilled lanes carry data=0 and keep=0.
//     IN_WIDTH == OUT_WIDTH: one-stage register slice.
//   RATIO = max/min width. It must be a power of two, and both widths must be
//   multiples of 8.
//
// Optional feature macro: AXIS_CONV_BYTECNT_EN
//   When defined, the io_dataOut_payload_fragment_byteNum output is added. It
//   carries the popcount of the output tkeep, zero-extended to 16 bits.
//
// Ports
//   clk, reset                          single clock; synchronous active-high reset
//   io_dataIn_valid/ready               input beat handshake
//   io_dataIn_payload_last              last beat of packet
//   io_dataIn_payload_fragment_data     IN_WIDTH data, byte 0 in bits [7:0]
//   io_dataIn_payload_fragment_tkeep    IN_WIDTH/8 byte enables
//   io_dataOut_valid/ready              output beat handshake
//   io_dataOut_payload_last             last beat of packet
//   io_dataOut_payload_fragment_data    OUT_WIDTH data
//   io_dataOut_payload_fragment_tkeep   OUT_WIDTH/8 byte enables
//   io_dataOut_payload_fragment_byteNum 16-bit byte count (macro only)
//   debug_state                         down: {0, EMPTY/SPLIT};
//                                       up: {lane idx != 0, out_valid};
//                                       equal: {0, out_valid}
//
// Handshake: a beat transfers on a rising edge where valid && ready are both
//   high. Once valid is high, valid/data/keep/last are held unchanged until
//   that transfer. No output depends combinationally on io_dataIn_*.
//   io_dataIn_ready is held low while reset is asserted.

module axis_width_conv #(
    parameter int IN_WIDTH  = 512,
    parameter int OUT_WIDTH = 256
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   io_dataIn_valid,
    output logic                   io_dataIn_ready,
    input  logic                   io_dataIn_payload_last,
    input  logic [IN_WIDTH-1:0]    io_dataIn_payload_fragment_data,
    input  logic [IN_WIDTH/8-1:0]  io_dataIn_payload_fragment_tkeep,
    output logic                   io_dataOut_valid,
    input  logic                   io_dataOut_ready,
    output logic                   io_dataOut_payload_last,
    output logic [OUT_WIDTH-1:0]   io_dataOut_payload_fragment_data,
    output logic [OUT_WIDTH/8-1:0] io_dataOut_payload_fragment_tkeep,
`ifdef AXIS_CONV_BYTECNT_EN
    output logic [15:0]            io_dataOut_payload_fragment_byteNum,
`endif
    output logic [1:0]             debug_state
);

    localparam int IN_KW    = IN_WIDTH / 8;
    localparam int OUT_KW   = OUT_WIDTH / 8;
    localparam int MAX_W    = (IN_WIDTH > OUT_WIDTH) ? IN_WIDTH : OUT_WIDTH;
    localparam int MIN_W    = (IN_WIDTH > OUT_WIDTH) ? OUT_WIDTH : IN_WIDTH;
    localparam int RATIO    = MAX_W / MIN_W;
    localparam int IDX_W    = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

    if (IN_WIDTH > OUT_WIDTH) begin : g_down
        typedef enum logic {S_EMPTY = 1'b0, S_SPLIT = 1'b1} down_state_t;

        down_state_t       state_q, state_d;
        logic [IDX_W-1:0]  idx_q, idx_d;
        logic [IN_WIDTH-1:0] buf_data_q;
        logic [IN_KW-1:0]  buf_keep_q;
        logic              buf_last_q;
        logic              upper_zero, sub_final, in_ready, in_fire, skip_beat, load;

        always_comb begin
            // On a last beat, a sub-beat with no bytes above it ends the packet.
            upper_zero = 1'b1;
            for (int l = 0; l < RATIO; l++) begin
                if ((l > int'(idx_q)) && (|buf_keep_q[l*OUT_KW +: OUT_KW])) begin
                    upper_zero = 1'b0;
                end
            end
            sub_final = (idx_q == LAST_IDX) || (buf_last_q && upper_zero);
            in_ready  = !reset && ((state_q == S_EMPTY) || (sub_final && io_dataOut_ready));
            in_fire   = io_dataIn_valid && in_ready;
            // A non-last beat with no bytes is consumed without producing output.
            skip_beat = !io_dataIn_payload_last && (io_dataIn_payload_fragment_tkeep == '0);
            load      = in_fire && !skip_beat;

            state_d = state_q;
            idx_d   = idx_q;
            if (load) begin
                state_d = S_SPLIT;
                idx_d   = '0;
            end else if ((state_q == S_SPLIT) && io_dataOut_ready) begin
                if (sub_final) begin
                    state_d = S_EMPTY;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                state_q    <= S_EMPTY;
                idx_q      <= '0;
                buf_data_q <= '0;
                buf_keep_q <= '0;
                buf_last_q <= 1'b0;
            end else begin
                state_q <= state_d;
                idx_q   <= idx_d;
                if (load) begin
                    buf_data_q <= io_dataIn_payload_fragment_data;
                    buf_keep_q <= io_dataIn_payload_fragment_tkeep;
                    buf_last_q <= io_dataIn_payload_last;
                end
            end
        end

        assign io_dataIn_ready                   = in_ready;
        assign io_dataOut_valid                  = (state_q == S_SPLIT);
        assign io_dataOut_payload_last           = (state_q == S_SPLIT) && buf_last_q && sub_final;
        assign io_dataOut_payload_fragment_data  = buf_data_q[int'(idx_q)*OUT_WIDTH +: OUT_WIDTH];
        assign io_dataOut_payload_fragment_tkeep = buf_keep_q[int'(idx_q)*OUT_KW +: OUT_KW];
        assign debug_state                       = {1'b0, state_q};

    end else if (IN_WIDTH < OUT_WIDTH) begin : g_up
        logic [OUT_WIDTH-1:0] acc_data_q, out_data_q, word_data;
        logic [OUT_KW-1:0]    acc_keep_q, out_keep_q, word_keep;
        logic [IDX_W-1:0]     idx_q;
        logic                 out_valid_q, out_last_q;
        logic                 in_ready, in_fire, complete;

        always_comb begin
            in_ready = !reset && (!out_valid_q || io_dataOut_ready);
            in_fire  = io_dataIn_valid && in_ready;
            complete = in_fire && ((idx_q == LAST_IDX) || io_dataIn_payload_last);

            // Completed word: filled lanes from the accumulator, current lane
            // from the input, and lanes above it cleared.
            word_data = '0;
            word_keep = '0;
            for (int l = 0; l < RATIO; l++) begin
                if (l < int'(idx_q)) begin
                    word_data[l*IN_WIDTH +: IN_WIDTH] = acc_data_q[l*IN_WIDTH +: IN_WIDTH];
                    word_keep[l*IN_KW +: IN_KW]       = acc_keep_q[l*IN_KW +: IN_KW];
                end else if (l == int'(idx_q)) begin
                    word_data[l*IN_WIDTH +: IN_WIDTH] = io_dataIn_payload_fragment_data;
                    word_keep[l*IN_KW +: IN_KW]       = io_dataIn_payload_fragment_tkeep;
                end
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                acc_data_q  <= '0;
                acc_keep_q  <= '0;
                idx_q       <= '0;
                out_data_q  <= '0;
                out_keep_q  <= '0;
                out_last_q  <= 1'b0;
                out_valid_q <= 1'b0;
            end else begin
                if (in_fire) begin
                    acc_data_q[int'(idx_q)*IN_WIDTH +: IN_WIDTH] <= io_dataIn_payload_fragment_data;
                    acc_keep_q[int'(idx_q)*IN_KW +: IN_KW]       <= io_dataIn_payload_fragment_tkeep;
                end
                if (complete) begin
                    // Covers the case where an accept and a new completion happen in
                    // the same cycle: the new word replaces the old one and valid stays high.
                    out_data_q  <= word_data;
                    out_keep_q  <= word_keep;
                    out_last_q  <= io_dataIn_payload_last;
                    out_valid_q <= 1'b1;
                    idx_q       <= '0;
                end else begin
                    if (in_fire) begin
                        idx_q <= idx_q + IDX_W'(1);
                    end
                    if (io_dataOut_ready) begin
                        out_valid_q <= 1'b0;
                    end
                end
            end
        end

        assign io_dataIn_ready                   = in_ready;
        assign io_dataOut_valid                  = out_valid_q;
        assign io_dataOut_payload_last           = out_last_q;
        assign io_dataOut_payload_fragment_data  = out_data_q;
        assign io_dataOut_payload_fragment_tkeep = out_keep_q;
        assign debug_state                       = {(idx_q != '0), out_valid_q};

    end else begin : g_equal
        logic [OUT_WIDTH-1:0] out_data_q;
        logic [OUT_KW-1:0]    out_keep_q;
        logic                 out_valid_q, out_last_q, in_ready;

        assign in_ready = !reset && (!out_valid_q || io_dataOut_ready);

        always_ff @(posedge clk) begin
            if (reset) begin
                out_data_q  <= '0;
                out_keep_q  <= '0;
                out_last_q  <= 1'b0;
                out_valid_q <= 1'b0;
            end else if (in_ready) begin
                out_valid_q <= io_dataIn_valid;
                if (io_dataIn_valid) begin
                    out_data_q <= io_dataIn_payload_fragment_data;
                    out_keep_q <= io_dataIn_payload_fragment_tkeep;
                    out_last_q <= io_dataIn_payload_last;
                end
            end
        end

        assign io_dataIn_ready                   = in_ready;
        assign io_dataOut_valid                  = out_valid_q;
        assign io_dataOut_payload_last           = out_last_q;
        assign io_dataOut_payload_fragment_data  = out_data_q;
        assign io_dataOut_payload_fragment_tkeep = out_keep_q;
        assign debug_state                       = {1'b0, out_valid_q};
    end

`ifdef AXIS_CONV_BYTECNT_EN
    // Derived only from registered output state, so it is valid together with the beat.
    always_comb begin
        io_dataOut_payload_fragment_byteNum = '0;
        for (int b = 0; b < OUT_KW; b++) begin
            io_dataOut_payload_fragment_byteNum = io_dataOut_payload_fragment_byteNum
                + {15'd0, io_dataOut_payload_fragment_tkeep[b]};
        end
    end
`endif

endmodule
